// File: rtl/fifo_sync_pkg.sv
// Shared helpers for async-FIFO pointer synchronisation: stage limits and
// Gray/binary conversion on a 32-bit container (callers zero-extend and truncate).
package fifo_sync_pkg;

  localparam int unsigned MIN_SYNC_STAGES = 2;
  localparam int unsigned MAX_SYNC_STAGES = 4;
  localparam int unsigned PTR_MAX_W       = 32;

  // Gray to binary: each binary bit is the XOR of all Gray bits at or above it
  function automatic logic [PTR_MAX_W-1:0] gray2bin(input logic [PTR_MAX_W-1:0] ptr);
    logic [PTR_MAX_W-1:0] bin;
    bin[PTR_MAX_W-1] = ptr[PTR_MAX_W-1];
    for (int i = PTR_MAX_W - 2; i >= 0; i--) begin
      bin[i] = bin[i+1] ^ ptr[i];
    end
    return bin;
  endfunction

  // Binary to Gray, used by the FIFO pointer counters
  function automatic logic [PTR_MAX_W-1:0] bin2gray(input logic [PTR_MAX_W-1:0] ptr);
    return ptr ^ (ptr >> 1);
  endfunction

  // Number of set bits, used for the Gray Hamming-distance check
  function automatic int unsigned popcount(input logic [PTR_MAX_W-1:0] ptr);
    int unsigned cnt;
    cnt = 0;
    for (int i = 0; i < PTR_MAX_W; i++) begin
      cnt += int'(ptr[i]);
    end
    return cnt;
  endfunction

endpackage

// File: rtl/sync_chain.sv
// WIDTH x STAGES flop chain for clock-domain crossing; STAGES must be >= 2.
module sync_chain #(
  parameter int unsigned WIDTH  = 1,
  parameter int unsigned STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [STAGES-1:0][WIDTH-1:0] stage_q;

  // Shift the input through the chain; stage 0 is the metastability catcher
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stage_q <= '0;
    end else begin
      stage_q <= {stage_q[STAGES-2:0], d_i};
    end
  end

  assign q_o = stage_q[STAGES-1];

endmodule

// File: rtl/gray_ptr_sync.sv
// Gray pointer synchroniser with registered binary, change pulse and delta.
// Optional Gray-step checker enabled by defining GRAY_PTR_SYNC_CHECK_EN.
module gray_ptr_sync
  import fifo_sync_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH  = 4,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                CLK,
  input  logic                RSTn,
  input  logic [ADDR_WIDTH:0] ptr_gray_in,
  input  logic                err_clr,
  output logic [ADDR_WIDTH:0] ptr_gray_sync,
  output logic [ADDR_WIDTH:0] ptr_bin,
  output logic                ptr_upd,
  output logic [ADDR_WIDTH:0] ptr_delta,
  output logic                ptr_err
);

  localparam int unsigned PTR_W = ADDR_WIDTH + 1;

  // Reject unsupported chain depths at elaboration
  if (SYNC_STAGES < MIN_SYNC_STAGES || SYNC_STAGES > MAX_SYNC_STAGES) begin : g_bad_stages
    $error("gray_ptr_sync: SYNC_STAGES must be within 2..4");
  end

  logic [PTR_W-1:0] gray_sync;
  logic [PTR_W-1:0] bin_c;
  logic [PTR_W-1:0] bin_d,   bin_q;
  logic             upd_d,   upd_q;
  logic [PTR_W-1:0] delta_d, delta_q;

  sync_chain #(
    .WIDTH  (PTR_W),
    .STAGES (SYNC_STAGES)
  ) u_sync_chain (
    .clk   (CLK),
    .rst_n (RSTn),
    .d_i   (ptr_gray_in),
    .q_o   (gray_sync)
  );

  assign bin_c = PTR_W'(gray2bin(PTR_MAX_W'(gray_sync)));

  // Next binary, change pulse and modulo advance; delta holds between changes
  always_comb begin
    bin_d   = bin_c;
    upd_d   = 1'b0;
    delta_d = delta_q;
    if (bin_c != bin_q) begin
      upd_d   = 1'b1;
      delta_d = PTR_W'(bin_c - bin_q);
    end
  end

  // Binary pointer, update pulse and delta registers
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      bin_q   <= '0;
      upd_q   <= 1'b0;
      delta_q <= '0;
    end else begin
      bin_q   <= bin_d;
      upd_q   <= upd_d;
      delta_q <= delta_d;
    end
  end

`ifdef GRAY_PTR_SYNC_CHECK_EN
  logic [PTR_W-1:0] prev_q;
  logic             viol_c;
  logic             err_d, err_q;

  assign viol_c = popcount(PTR_MAX_W'(gray_sync ^ prev_q)) > 1;

  // Sticky flag; a new violation beats a simultaneous clear
  always_comb begin
    err_d = err_q;
    if (viol_c) begin
      err_d = 1'b1;
    end else if (err_clr) begin
      err_d = 1'b0;
    end
  end

  // Previous synchronised Gray value and error flag
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      prev_q <= '0;
      err_q  <= 1'b0;
    end else begin
      prev_q <= gray_sync;
      err_q  <= err_d;
    end
  end

  assign ptr_err = err_q;
`else
  logic unused_err_clr;
  assign unused_err_clr = err_clr;
  assign ptr_err        = 1'b0;
`endif

  assign ptr_gray_sync = gray_sync;
  assign ptr_bin       = bin_q;
  assign ptr_upd       = upd_q;
  assign ptr_delta     = delta_q;

endmodule

// File: tb/tb_gray_ptr_sync.sv
// Bench for gray_ptr_sync: two instances (2 and 3 stages) on a shared input,
// compared against a sample-history model of the pointer crossing.
module tb_gray_ptr_sync;

`ifdef GRAY_PTR_SYNC_CHECK_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  logic       CLK;
  logic       RSTn;
  logic [4:0] ptr_gray_in;
  logic       err_clr;

  logic [4:0] sync2, bin2, delta2;
  logic       upd2, err2;
  logic [4:0] sync3, bin3, delta3;
  logic       upd3, err3;

  int checks   = 0;
  int failures = 0;

  gray_ptr_sync #(.ADDR_WIDTH(4), .SYNC_STAGES(2)) u_dut2 (
    .CLK(CLK), .RSTn(RSTn), .ptr_gray_in(ptr_gray_in), .err_clr(err_clr),
    .ptr_gray_sync(sync2), .ptr_bin(bin2), .ptr_upd(upd2),
    .ptr_delta(delta2), .ptr_err(err2)
  );

  gray_ptr_sync #(.ADDR_WIDTH(4), .SYNC_STAGES(3)) u_dut3 (
    .CLK(CLK), .RSTn(RSTn), .ptr_gray_in(ptr_gray_in), .err_clr(err_clr),
    .ptr_gray_sync(sync3), .ptr_bin(bin3), .ptr_upd(upd3),
    .ptr_delta(delta3), .ptr_err(err3)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  // Model: h[k] is the input value captured k edges ago (h[0] = latest edge)
  logic [4:0] h [0:7];
  logic [4:0] e_delta [2];
  logic       e_upd   [2];
  logic       e_err   [2];

  function automatic logic [4:0] to_gray(input int b);
    return 5'((b ^ (b >> 1)) & 31);
  endfunction

  // Binary value whose Gray encoding matches g, found by table search
  function automatic int from_gray(input logic [4:0] g);
    for (int b = 0; b < 32; b++) begin
      if (to_gray(b) == g) return b;
    end
    return -1;
  endfunction

  task automatic check(input string tag, input logic [4:0] obs, input logic [4:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 8; k++) h[k] = 5'd0;
    for (int s = 0; s < 2; s++) begin
      e_delta[s] = 5'd0;
      e_upd[s]   = 1'b0;
      e_err[s]   = 1'b0;
    end
  endtask

  task automatic model_edge(input logic [4:0] v, input logic c);
    int nb, ob, st;
    bit viol;
    for (int k = 7; k > 0; k--) h[k] = h[k-1];
    h[0] = v;
    for (int s = 0; s < 2; s++) begin
      st = s + 2;
      nb = from_gray(h[st]);
      ob = from_gray(h[st+1]);
      e_upd[s] = (nb != ob);
      if (nb != ob) e_delta[s] = 5'((nb - ob + 32) % 32);
      viol = $countones(h[st] ^ h[st+1]) > 1;
      if (!ERR_EN)   e_err[s] = 1'b0;
      else if (viol) e_err[s] = 1'b1;
      else if (c)    e_err[s] = 1'b0;
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, ".sync2"},  sync2,  h[1]);
    check({tag, ".bin2"},   bin2,   5'(from_gray(h[2])));
    check({tag, ".upd2"},   5'(upd2),   5'(e_upd[0]));
    check({tag, ".delta2"}, delta2, e_delta[0]);
    check({tag, ".err2"},   5'(err2),   5'(e_err[0]));
    check({tag, ".sync3"},  sync3,  h[2]);
    check({tag, ".bin3"},   bin3,   5'(from_gray(h[3])));
    check({tag, ".upd3"},   5'(upd3),   5'(e_upd[1]));
    check({tag, ".delta3"}, delta3, e_delta[1]);
    check({tag, ".err3"},   5'(err3),   5'(e_err[1]));
  endtask

  // Drive one input value across one CLK edge, then compare everything
  task automatic step(input string tag, input logic [4:0] v, input logic c);
    ptr_gray_in = v;
    err_clr     = c;
    @(posedge CLK);
    model_edge(v, c);
    #1;
    check_all(tag);
  endtask

  task automatic hold_steps(input string tag, input logic [4:0] v, input int n);
    for (int i = 0; i < n; i++) step(tag, v, 1'b0);
  endtask

  int b;
  int upd_seen;
  logic [4:0] delta_before;

  initial begin
    RSTn = 1'b0;
    ptr_gray_in = 5'd0;
    err_clr = 1'b0;
    #3;
    model_reset();
    #1;
    check_all("reset");
    @(negedge CLK);
    RSTn = 1'b1;

    // Input 00011 after reset: sync after 2 edges, binary 2 after 3
    step("rst_e1", 5'b00011, 1'b0);
    step("rst_e2", 5'b00011, 1'b0);
    check("rst_sync_at2", sync2, 5'b00011);
    step("rst_e3", 5'b00011, 1'b0);
    check("rst_bin_at3", bin2, 5'd2);
    check("rst_err_at3", 5'(err2), 5'(ERR_EN));
    step("rst_clr", 5'b00011, 1'b1);
    step("rst_clr", 5'b00011, 1'b1);
    hold_steps("settle", 5'b00011, 3);

    // Random single-count walk with occasional clears
    b = 2;
    for (int i = 0; i < 80; i++) begin
      b = (b + int'($urandom_range(0, 1))) % 32;
      step("walk", to_gray(b), ($urandom_range(0, 7) == 0));
    end

    // Wrap-around 30 -> 31 -> 0 -> 1
    hold_steps("wrap_pre", to_gray(30), 5);
    step("wrap31", to_gray(31), 1'b0);
    step("wrap0",  to_gray(0),  1'b0);
    step("wrap1",  to_gray(1),  1'b0);
    check("wrap_delta_31", delta2, 5'd1);
    step("wrap_t1", to_gray(1), 1'b0);
    check("wrap_delta_0", delta2, 5'd1);
    check("wrap_bin_0", bin2, 5'd0);
    step("wrap_t2", to_gray(1), 1'b0);
    check("wrap_delta_1", delta2, 5'd1);
    check("wrap_upd_1", 5'(upd2), 5'd1);

    // Skip count: 4 -> 5 -> 6 -> 7 between two CLK edges
    hold_steps("skip_pre", to_gray(4), 5);
    ptr_gray_in = to_gray(5);
    #1 ptr_gray_in = to_gray(6);
    #1;
    step("skip7", to_gray(7), 1'b0);
    step("skip_t1", to_gray(7), 1'b0);
    step("skip_t2", to_gray(7), 1'b0);
    check("skip_upd", 5'(upd2), 5'd1);
    check("skip_delta", delta2, 5'd3);
    check("skip_err", 5'(err2), 5'd0);
    hold_steps("skip_post", to_gray(7), 3);

    // Gray violation, clear racing a new violation, then clear alone
    hold_steps("viol_pre0", 5'b00000, 5);
    step("viol_clr", 5'b00000, 1'b1);
    step("viol_clr", 5'b00000, 1'b1);
    step("viol_j1", 5'b00011, 1'b0);
    step("viol_t1", 5'b00011, 1'b0);
    step("viol_t2", 5'b00011, 1'b0);
    check("viol_set", 5'(err2), 5'(ERR_EN));
    step("viol_j2", 5'b00000, 1'b0);
    step("viol_t3", 5'b00000, 1'b0);
    step("viol_race", 5'b00000, 1'b1);
    check("viol_race_err", 5'(err2), 5'(ERR_EN));
    step("viol_clr_only", 5'b00000, 1'b1);
    check("viol_cleared", 5'(err2), 5'd0);
    step("viol_clr3", 5'b00000, 1'b1);

    // Hold for 100 cycles: no pulses, delta frozen
    hold_steps("hold_pre", to_gray(9), 4);
    delta_before = delta2;
    upd_seen = 0;
    for (int i = 0; i < 100; i++) begin
      step("hold", to_gray(9), 1'b0);
      if (upd2) upd_seen++;
    end
    check("hold_no_upd", 5'(upd_seen), 5'd0);
    check("hold_delta", delta2, delta_before);

    // Asynchronous reset mid-run with a nonzero input
    step("arst_pre", to_gray(12), 1'b0);
    step("arst_pre", to_gray(13), 1'b0);
    #2 RSTn = 1'b0;
    #1;
    model_reset();
    check_all("arst");
    @(negedge CLK);
    RSTn = 1'b1;
    hold_steps("arst_post", 5'd0, 4);

    // Random multi-count jumps (may violate) with random clears
    b = 0;
    for (int i = 0; i < 120; i++) begin
      b = (b + int'($urandom_range(0, 3))) % 32;
      step("jump", to_gray(b), ($urandom_range(0, 3) == 0));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/gray_ptr_sync.md
Name: gray_ptr_sync

Overview:
Parametrised successor to the two-flop pointer synchroniser used in the async FIFO. It brings a Gray-coded pointer from a foreign clock domain into the local domain through a configurable-depth flop chain. It also registers the binary equivalent, pulses on every change, and reports the pointer advance since the last change. It sits on both FIFO sides (read-to-write and write-to-read) as one shared cell.

Parameters:
- ADDR_WIDTH, 4, FIFO address width; pointer width is ADDR_WIDTH+1.
- SYNC_STAGES, 2, number of synchroniser flops; legal range 2..4; any other value is an elaboration error.

Ports:
- CLK  input  1  local (destination) clock.
- RSTn  input  1  asynchronous active-low reset.
- ptr_gray_in  input  ADDR_WIDTH+1  Gray pointer from the foreign domain; no timing relation to CLK.
- err_clr  input  1  synchronous clear of ptr_err.
- ptr_gray_sync  output  ADDR_WIDTH+1  last synchroniser stage (Gray).
- ptr_bin  output  ADDR_WIDTH+1  registered binary of ptr_gray_sync.
- ptr_upd  output  1  one-cycle pulse when ptr_bin changes.
- ptr_delta  output  ADDR_WIDTH+1  ptr_bin(new) − ptr_bin(old), modulo 2^(ADDR_WIDTH+1); valid with ptr_upd, held otherwise.
- ptr_err  output  1  sticky Gray-violation flag.

Behaviour:
- Clock and reset: one clock, CLK. Reset is asynchronous and active-low on RSTn.
- Reset values: all synchroniser stages, ptr_gray_sync, ptr_bin, ptr_upd, ptr_delta and ptr_err are 0. Reset mid-operation clears everything on the next RSTn assertion, regardless of CLK.
- Synchroniser chain:
  - Stage 1 samples ptr_gray_in each CLK edge.
  - Stage k samples stage k−1.
  - ptr_gray_sync is stage SYNC_STAGES.
- Latency: a stable input change appears on ptr_gray_sync after SYNC_STAGES edges. ptr_bin, ptr_upd and ptr_delta follow one edge later (SYNC_STAGES+1 total).
- Binary conversion:
  - bin[MSB] = gray[MSB].
  - bin[i] = bin[i+1] XOR gray[i].
  - Combinational from ptr_gray_sync, then registered into ptr_bin.
- Update detection:
  - ptr_upd = 1 for exactly one cycle when the newly registered binary differs from the previous ptr_bin.
  - An unchanged value gives ptr_upd = 0.
  - Back-to-back changes give consecutive pulses.
- Delta arithmetic: ptr_delta is an unsigned subtraction truncated to ADDR_WIDTH+1 bits, so wrap-around is handled. Example at ADDR_WIDTH=4: old 31, new 1 → delta 2.
- Gray check:
  - Compare ptr_gray_sync against its value one cycle earlier.
  - A Hamming distance > 1 sets ptr_err on the next edge.
  - ptr_err stays set until err_clr or reset.
  - If err_clr and a new violation occur in the same cycle, the violation wins and ptr_err stays 1.
- Multi-step jumps: a foreign domain faster than CLK may advance several counts between samples. This is legal and reported via ptr_delta > 1. It is not an error as long as each synchronised transition is a single-bit Gray step.

Optional Feature:
- Macro: GRAY_PTR_SYNC_CHECK_EN.
- Defined: the Gray-check logic and the err_clr path are built as above.
- Undefined: no check logic is built; ptr_err is tied to 0 and err_clr is ignored. All other behaviour is identical.

Decomposition:
- Shared package fifo_sync_pkg holds:
  - constant MIN_SYNC_STAGES = 2 and MAX_SYNC_STAGES = 4;
  - function gray2bin(ptr);
  - function bin2gray(ptr), used by the FIFO pointer logic;
  - function popcount for the Hamming check.
- One sub-module, sync_chain: a parametrised WIDTH × STAGES flop chain with async active-low reset. It is instantiated once and is reusable for single-bit flag synchronisation elsewhere.

Test Plan:
- Reset: assert RSTn = 0 mid-run with a nonzero input → all outputs 0 asynchronously; after release, input 5'b00011 gives ptr_gray_sync = 00011 after 2 edges and ptr_bin = 2 after 3 edges.
- Stage sweep: with SYNC_STAGES = 3, step the input 00000 → 00001 → ptr_gray_sync changes on edge 3, ptr_upd pulses once on edge 4, ptr_delta = 1.
- Wrap: step the Gray sequence binary 30 → 31 → 0 → 1 in consecutive CLK cycles → ptr_delta = 1 each step, no ptr_err.
- Skip count: hold the input, then jump from the Gray of 4 to the Gray of 7 through single-bit steps over 3 foreign-domain edges, sampled only at the final value → one ptr_upd with ptr_delta = 3, ptr_err = 0.
- Violation: the input jumps from 00000 to 00011 in one cycle → ptr_err = 1 after SYNC_STAGES+1 edges. Then err_clr and a fresh 00011 → 00000 jump in the same cycle → ptr_err stays 1. err_clr alone → 0. With the macro undefined, ptr_err stays 0 throughout.
- Hold: a constant input for 100 cycles → ptr_upd never asserts and ptr_delta holds its last value.
